gf2_poly_div_seq: RTL and testbench

//  Sequential GF(2) polynomial divider: the inverse of the combinational carry-less
//  AND/XOR product slices. Divides a NW-bit dividend polynomial by a DW-bit divisor,

---
 rtl/gf2_poly_div_seq.sv | 106 ++++++++++
 tb/tb_gf2_poly_div_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gf2_poly_div_seq.sv
// Sequential GF(2) polynomial divider: one dividend bit per clock, MSB first,
// producing quotient, remainder and a divide-by-zero flag behind valid/ready.
module gf2_poly_div_seq #(
   parameter int NW = 16,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [NW-1:0] dividend,
   input  logic [DW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [NW-1:0] quotient,
   output logic [DW-2:0] remainder,
   output logic          div_zero
);

   localparam int CW  = (NW > 1) ? $clog2(NW) : 1;
   localparam int DGW = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nx;
   logic [NW-1:0]   dvd;
   logic [DW-1:0]   dvs;
   logic [DGW-1:0]  deg;
   logic            zero;
   logic [CW-1:0]   cnt;
   logic [DW-1:0]   acc;
   logic [NW-1:0]   quot_w;

   logic [DW-1:0]   t;
   logic            sub;
   logic [DW-1:0]   acc_nx;
   logic [NW-1:0]   quot_nx;
   logic            accept;

   // Index of the highest set coefficient; 0 for an all-zero input.
   function automatic logic [DGW-1:0] msb_idx(input logic [DW-1:0] v);
      msb_idx = '0;
      for (int i = 0; i < DW; i++)
         if (v[i]) msb_idx = DGW'(i);
   endfunction

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = RUN;
         RUN:     if (cnt == '0) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // One long-division step; a zero divisor never subtracts, so acc ends up
   // holding the low dividend bits and the quotient stays zero.
   always_comb begin
      t            = {acc[DW-2:0], dvd[cnt]};
      sub          = t[deg] && !zero;
      acc_nx       = sub ? (t ^ dvs) : t;
      quot_nx      = quot_w;
      quot_nx[cnt] = sub;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (state == IDLE) begin
         if (in_valid) begin
            dvd    <= dividend;
            dvs    <= divisor;
            deg    <= msb_idx(divisor);
            zero   <= (divisor == '0);
            acc    <= '0;
            quot_w <= '0;
            cnt    <= CW'(NW - 1);
         end
      end else if (state == RUN) begin
         acc    <= acc_nx;
         quot_w <= quot_nx;
         cnt    <= cnt - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
      end else if (state == RUN && cnt == '0) begin
         quotient  <= quot_nx;
         remainder <= acc_nx[DW-2:0];
         div_zero  <= zero;
      end
   end

endmodule

// File: tb/tb_gf2_poly_div_seq.sv
// Directed and random checks of gf2_poly_div_seq against a reference
// long-division model, with results queued at issue and compared at completion.
module tb_gf2_poly_div_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic [6:0]  remainder;
   logic        div_zero;

   typedef struct {
      logic [15:0] q;
      logic [6:0]  r;
      logic        z;
   } exp_t;

   exp_t sb[$];
   exp_t last;
   int   n_checks = 0;
   int   n_fail   = 0;

   gf2_poly_div_seq #(.NW(16), .DW(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
      .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
      .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
      exp_t        e;
      logic [15:0] rem;
      int          d;
      rem = a;
      d   = -1;
      e.q = '0;
      for (int i = 0; i < 8; i++) if (b[i]) d = i;
      if (d < 0) begin
         e.z = 1'b1;
         e.r = a[6:0];
      end else begin
         for (int i = 15; i >= d; i--)
            if (rem[i]) begin
               rem = rem ^ (16'(b) << (i - d));
               e.q[i-d] = 1'b1;
            end
         e.z = 1'b0;
         e.r = rem[6:0];
      end
      return e;
   endfunction

   function automatic logic [22:0] clmul(input logic [15:0] q, input logic [7:0] b);
      logic [22:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (23'(q) << i);
      return p;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [15:0] a, input logic [7:0] b);
      @(negedge clk);
      check("in_ready_idle", 32'(in_ready), 32'd1);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      sb.push_back(model(a, b));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("latency", 32'(n), 32'd16);
      if (sb.size() > 0) last = sb.pop_front();
      check("quotient", 32'(quotient), 32'(last.q));
      check("remainder", 32'(remainder), 32'(last.r));
      check("div_zero", 32'(div_zero), 32'(last.z));
      check("in_ready_done", 32'(in_ready), 32'd0);
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("out_valid_drop", 32'(out_valid), 32'd0);
      check("in_ready_back", 32'(in_ready), 32'd1);
   endtask

   task automatic run_op(input logic [15:0] a, input logic [7:0] b, input bit early_ready);
      start_op(a, b);
      if (early_ready) out_ready = 1'b1;
      wait_done();
      release_out();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_quotient", 32'(quotient), 32'd0);
      check("rst_remainder", 32'(remainder), 32'd0);
      check("rst_div_zero", 32'(div_zero), 32'd0);

      // Directed cases with spelled-out results.
      run_op(16'h0005, 8'h03, 1'b0);
      check("t1_q", 32'(last.q), 32'h0003);
      run_op(16'h0007, 8'h03, 1'b0);
      check("t2_q_const", 32'(quotient), 32'h0002);
      check("t2_r_const", 32'(remainder), 32'h01);
      run_op(16'hABCD, 8'h80, 1'b1);
      check("t3_q_const", 32'(quotient), 32'h0157);
      check("t3_r_const", 32'(remainder), 32'h4D);
      run_op(16'hABCD, 8'h01, 1'b0);
      check("t3b_q_const", 32'(quotient), 32'hABCD);
      check("t3b_r_const", 32'(remainder), 32'h00);
      run_op(16'h1234, 8'h00, 1'b0);
      check("t4_z_const", 32'(div_zero), 32'd1);
      check("t4_q_const", 32'(quotient), 32'h0000);
      check("t4_r_const", 32'(remainder), 32'h34);

      // Backpressure in DONE with a stray request that must be ignored.
      start_op(16'hC3A5, 8'h1B);
      wait_done();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         dividend = 16'hFFFF;
         divisor  = 8'h05;
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_quotient", 32'(quotient), 32'(last.q));
         check("bp_remainder", 32'(remainder), 32'(last.r));
      end
      in_valid = 1'b0;
      release_out();
      repeat (3) @(posedge clk);
      #1;
      check("bp_no_extra_op", 32'(out_valid), 32'd0);
      check("bp_still_idle", 32'(in_ready), 32'd1);

      // Reset five clocks into RUN discards the pending result.
      start_op(16'hBEEF, 8'h1D);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      if (sb.size() > 0) void'(sb.pop_front());
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_quotient", 32'(quotient), 32'd0);
      repeat (20) @(posedge clk);
      #1;
      check("mid_rst_no_result", 32'(out_valid), 32'd0);
      run_op(16'h8001, 8'h0B, 1'b0);

      // Random sweep including the reconstruction identity.
      for (int k = 0; k < 24; k++) begin
         logic [15:0] a;
         logic [7:0]  b;
         a = 16'($urandom);
         b = (k == 0) ? 8'h00 : 8'($urandom);
         start_op(a, b);
         if (k[0]) out_ready = 1'b1;
         wait_done();
         if (b != 8'h00)
            check("identity", 32'(clmul(quotient, b) ^ 23'(remainder)), 32'(a));
         release_out();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
